// File: rtl/ym_dbg_capture.sv
// Serial-to-parallel capture for the tail of a shift-register debug readout chain.
// Optional trailing even-parity bit is enabled by defining DBG_CAPTURE_PARITY_EN.
module ym_dbg_capture #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                  MCLK,
  input  logic                  reset,
  input  logic                  c1,
  input  logic                  start,
  input  logic                  sin,
  input  logic                  ack,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  busy,
  output logic                  overrun,
  output logic                  parity_err
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 2);
`ifdef DBG_CAPTURE_PARITY_EN
  localparam int unsigned FrameLen = DATA_WIDTH + 1;
`else
  localparam int unsigned FrameLen = DATA_WIDTH;
`endif
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameLen - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  ovr_q, ovr_d;
  logic                  shifted_in;
`ifdef DBG_CAPTURE_PARITY_EN
  localparam logic [CntW-1:0] DataCnt = CntW'(DATA_WIDTH);
  logic par_q, par_d;
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    shifted_in = 1'b0;
`ifdef DBG_CAPTURE_PARITY_EN
    par_d      = par_q;
    perr_d     = perr_q;
`endif

    if (valid_q && ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (c1 && start) begin
          state_d = StShift;
          cnt_d   = '0;
          sreg_d  = '0;
        end
      end
      StShift: begin
        if (c1 && start) begin
          // Chain reloaded itself: restart the frame from scratch.
          cnt_d  = '0;
          sreg_d = '0;
        end else if (c1) begin
`ifdef DBG_CAPTURE_PARITY_EN
          if (cnt_q < DataCnt) shifted_in = 1'b1;
          else                 par_d      = sin;
`else
          shifted_in = 1'b1;
`endif
          cnt_d = cnt_q + CntOne;
          if (cnt_q == LastCnt) state_d = StDone;
        end
        if (shifted_in) begin
          if (MSB_FIRST) begin
            sreg_d    = sreg_q << 1;
            sreg_d[0] = sin;
          end else begin
            sreg_d                 = sreg_q >> 1;
            sreg_d[DATA_WIDTH-1]   = sin;
          end
        end
      end
      StDone: begin
        if (!valid_q || ack) begin
          data_d  = sreg_q;
          valid_d = 1'b1;
`ifdef DBG_CAPTURE_PARITY_EN
          perr_d  = (^sreg_q) ^ par_q;
`endif
        end else begin
          ovr_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = StIdle;
        if (c1 && start) begin
          state_d = StShift;
          sreg_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StShift);
  end

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sreg_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef DBG_CAPTURE_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
`ifdef DBG_CAPTURE_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign overrun  = ovr_q;
`ifdef DBG_CAPTURE_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ym_dbg_capture.sv
// Scoreboard bench for ym_dbg_capture: LSB-first and MSB-first instances share one
// serial stream; each scenario lives in its own task.
module tb_ym_dbg_capture;
  localparam int W = 8;

  logic MCLK, reset, c1, start, sin, ack;
  logic [W-1:0] dout_l, dout_m;
  logic valid_l, valid_m, busy_l, busy_m, ovr_l, ovr_m, perr_l, perr_m;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_l[$];
  logic [W-1:0] exp_m[$];
  bit           model_valid, model_ovr, model_perr;
  logic [W-1:0] model_dl, model_dm;

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  ym_dbg_capture #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .MCLK(MCLK), .reset(reset), .c1(c1), .start(start), .sin(sin), .ack(ack),
    .data_out(dout_l), .valid(valid_l), .busy(busy_l), .overrun(ovr_l), .parity_err(perr_l)
  );

  ym_dbg_capture #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .MCLK(MCLK), .reset(reset), .c1(c1), .start(start), .sin(sin), .ack(ack),
    .data_out(dout_m), .valid(valid_m), .busy(busy_m), .overrun(ovr_m), .parity_err(perr_m)
  );

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  // Inputs change 1 time unit after the active edge; outputs are read at the same point.
  task automatic cyc(input logic c, input logic s, input logic b, input logic a);
    c1 = c; start = s; sin = b; ack = a;
    @(posedge MCLK);
    #1;
  endtask

  task automatic start_frame();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // seq[i] is the i-th bit on sin; the DONE cycle is left to the caller.
  task automatic body(input logic [W-1:0] seq, input logic pbit, input bit ackd, input int from);
    for (int i = from; i < W; i++) begin
      cyc(1'b0, 1'b0, seq[i], 1'b0);
      cyc(1'b1, 1'b0, seq[i], 1'b0);
    end
`ifdef DBG_CAPTURE_PARITY_EN
    cyc(1'b0, 1'b0, pbit, 1'b0);
    cyc(1'b1, 1'b0, pbit, 1'b0);
`else
    sin = pbit;
`endif
    if (!model_valid || ackd) begin
      exp_l.push_back(seq);
      exp_m.push_back(rev(seq));
      model_dl    = seq;
      model_dm    = rev(seq);
      model_valid = 1'b1;
      if (ackd) model_ovr = 1'b0;
`ifdef DBG_CAPTURE_PARITY_EN
      model_perr = (^seq) ^ pbit;
`endif
    end else begin
      model_ovr = 1'b1;
    end
  endtask

  task automatic collect(input string name, output int waited);
    logic [W-1:0] el, em;
    waited = 0;
    while (!valid_l && waited < 4) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      waited++;
    end
    n_tests++;
    if (!valid_l) begin
      n_fail++;
      $display("FAIL %s: valid timeout, got %b want 1", name, valid_l);
    end else if (exp_l.size() == 0 || exp_m.size() == 0) begin
      n_fail++;
      $display("FAIL %s: output 0x%02h with empty scoreboard, want none", name, dout_l);
    end else begin
      el = exp_l.pop_front();
      em = exp_m.pop_front();
      if (dout_l !== el || dout_m !== em) begin
        n_fail++;
        $display("FAIL %s: data lsb=0x%02h msb=0x%02h want 0x%02h 0x%02h",
                 name, dout_l, dout_m, el, em);
      end
    end
    n_tests++;
    if (perr_l !== model_perr || perr_m !== model_perr) begin
      n_fail++;
      $display("FAIL %s_perr: got %b/%b want %b", name, perr_l, perr_m, model_perr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({dout_l, dout_m, valid_l, valid_m, busy_l, busy_m, ovr_l, ovr_m, perr_l, perr_m}
        !== '0) begin
      n_fail++;
      $display("FAIL reset: d=0x%02h/0x%02h v=%b b=%b o=%b p=%b want all 0",
               dout_l, dout_m, valid_l, busy_l, ovr_l, perr_l);
    end
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_gated();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (busy_l !== 1'b0 || busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL start_no_c1: busy %b/%b want 0", busy_l, busy_m);
    end
  endtask

  task automatic test_basic();
    int k;
    start_frame();
    n_tests++;
    if (busy_l !== 1'b1 || busy_m !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rise: busy %b/%b want 1", busy_l, busy_m);
    end
    body(8'hA5, ^8'hA5, 1'b0, 0);
    n_tests++;
    if (valid_l !== 1'b0) begin
      n_fail++;
      $display("FAIL early_valid: valid %b want 0", valid_l);
    end
    collect("basic_a5", k);
    n_tests++;
    if (k != 1 || busy_l !== 1'b0 || ovr_l !== 1'b0 || ovr_m !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_status: latency=%0d busy=%b ovr=%b want 1 0 0", k, busy_l, ovr_l);
    end
  endtask

  task automatic test_ack();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    model_valid = 1'b0;
    n_tests++;
    if (valid_l !== 1'b0 || valid_m !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_clear: valid %b/%b want 0", valid_l, valid_m);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (valid_l !== 1'b0 || dout_l !== model_dl || dout_m !== model_dm) begin
      n_fail++;
      $display("FAIL ack_idle: valid=%b d=0x%02h want 0 0x%02h", valid_l, dout_l, model_dl);
    end
  endtask

  task automatic test_overrun();
    int k;
    start_frame();
    body(8'h3C, ^8'h3C, 1'b0, 0);
    collect("ovr_first", k);
    start_frame();
    body(8'hFF, ^8'hFF, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (dout_l !== model_dl || dout_m !== model_dm || valid_l !== model_valid ||
        ovr_l !== model_ovr || ovr_m !== model_ovr) begin
      n_fail++;
      $display("FAIL overrun: d=0x%02h v=%b o=%b want 0x%02h %b %b",
               dout_l, valid_l, ovr_l, model_dl, model_valid, model_ovr);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    model_valid = 1'b0;
    model_ovr   = 1'b0;
    n_tests++;
    if (valid_l !== 1'b0 || ovr_l !== 1'b0 || ovr_m !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_ack: valid=%b ovr=%b/%b want 0 0", valid_l, ovr_l, ovr_m);
    end
  endtask

  task automatic test_abort();
    int k;
    start_frame();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
    end
    start_frame();
    body(8'h81, ^8'h81, 1'b0, 0);
    collect("abort_81", k);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    model_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (valid_l !== 1'b0 || exp_l.size() != 0) begin
      n_fail++;
      $display("FAIL abort_extra: valid=%b pending=%0d want 0 0", valid_l, exp_l.size());
    end
  endtask

  task automatic test_done_restart();
    int k;
    start_frame();
    body(8'h11, ^8'h11, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (busy_l !== 1'b1 || valid_l !== 1'b1) begin
      n_fail++;
      $display("FAIL done_restart: busy=%b valid=%b want 1 1", busy_l, valid_l);
    end
    collect("restart_11", k);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    model_valid = 1'b0;
    body(8'h22, ^8'h22, 1'b0, 0);
    collect("restart_22", k);
  endtask

  task automatic test_commit_with_ack();
    int k;
    start_frame();
    body(8'h4B, ^8'h4B, 1'b1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (valid_l !== 1'b1 || ovr_l !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_ack: valid=%b ovr=%b want 1 0", valid_l, ovr_l);
    end
    collect("commit_4b", k);
  endtask

  task automatic test_freeze();
    int k;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    model_valid = 1'b0;
    start_frame();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'(8'h96 >> i), 1'b0);
      cyc(1'b1, 1'b0, 1'(8'h96 >> i), 1'b0);
    end
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'($urandom), 1'b0);
    n_tests++;
    if (busy_l !== 1'b1 || valid_l !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze: busy=%b valid=%b want 1 0", busy_l, valid_l);
    end
    body(8'h96, ^8'h96, 1'b0, 3);
    collect("freeze_96", k);
  endtask

  task automatic test_reset_mid();
    int k;
    start_frame();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({dout_l, dout_m, valid_l, valid_m, busy_l, busy_m, ovr_l, ovr_m, perr_l, perr_m}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: d=0x%02h v=%b b=%b o=%b want all 0",
               dout_l, valid_l, busy_l, ovr_l);
    end
    @(posedge MCLK);
    #1 reset = 1'b1;
    model_valid = 1'b0;
    model_ovr   = 1'b0;
    model_perr  = 1'b0;
    model_dl    = '0;
    model_dm    = '0;
    exp_l.delete();
    exp_m.delete();
    start_frame();
    body(8'h5A, ^8'h5A, 1'b0, 0);
    collect("post_reset_5a", k);
  endtask

`ifdef DBG_CAPTURE_PARITY_EN
  task automatic test_parity();
    int k;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    model_valid = 1'b0;
    start_frame();
    body(8'h07, 1'b1, 1'b0, 0);
    collect("parity_good", k);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    model_valid = 1'b0;
    start_frame();
    body(8'h07, 1'b0, 1'b0, 0);
    collect("parity_bad", k);
    n_tests++;
    if (perr_l !== 1'b1 || dout_l !== 8'h07) begin
      n_fail++;
      $display("FAIL parity_err: perr=%b d=0x%02h want 1 0x07", perr_l, dout_l);
    end
  endtask
`endif

  initial begin
    c1 = 1'b0; start = 1'b0; sin = 1'b0; ack = 1'b0; reset = 1'b0;
    model_valid = 1'b0; model_ovr = 1'b0; model_perr = 1'b0;
    model_dl = '0; model_dm = '0;
    test_reset();
    test_start_gated();
    test_basic();
    test_ack();
    test_overrun();
    test_abort();
    test_done_restart();
    test_commit_with_ack();
    test_freeze();
    test_reset_mid();
`ifdef DBG_CAPTURE_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ym_dbg_capture.md
Name: ym_dbg_capture

Overview:
- Serial-to-parallel receiver for the debug readout chains built from the shift-register debug cells.
- A chain parallel-loads a register snapshot on a load strobe, then shifts it out one bit per c1 cycle. This block sits at the chain's tail, counts bits after the strobe, and rebuilds the word.
- It presents the word with a valid/ack handshake to the register-bus or test-port logic.
- It runs on MCLK and is qualified by the same c1 phase enable as the chain.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (1..32).
- MSB_FIRST, 0, bit order on sin: 0 = LSB first (right-shifting chain), 1 = MSB first (left-shifting chain).

Ports:
- MCLK  input  1  master clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- c1  input  1  phase-1 enable; all sampling and state changes happen only on MCLK edges with c1=1.
- start  input  1  frame start; the same strobe that drives the chain's load input.
- sin  input  1  serial data from the chain's next output.
- ack  input  1  consumer accepts data_out; effective only while valid=1.
- data_out  output  DATA_WIDTH  last completed word.
- valid  output  1  data_out holds an unconsumed word.
- busy  output  1  frame in progress (state SHIFT).
- overrun  output  1  sticky; a completed frame was dropped because valid was still set.
- parity_err  output  1  parity status of the last accepted word (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, bit counter=0, shift register=0. data_out=0, valid=0, busy=0, overrun=0, parity_err=0.
- Reset asserted mid-frame discards the partial word immediately.
- Frame length: N = DATA_WIDTH, or DATA_WIDTH+1 with the optional feature.
- States:
  - IDLE: start=1 and c1=1 → SHIFT, counter cleared. start with c1=0 is ignored.
  - SHIFT: on each c1 edge with start=0, sample sin into the shift register and increment the counter.
    - First sample is taken on the c1 edge after the start edge (the chain's first bit is valid only after that).
    - MSB_FIRST=0: register shifts right, sin enters the top bit. MSB_FIRST=1: register shifts left, sin enters bit 0.
    - After the N-th sample → DONE.
  - SHIFT with start=1 and c1=1: abort the current frame; counter cleared; stay in SHIFT. This restart matches the chain reloading itself.
  - DONE: one MCLK cycle, independent of c1. Commits the word, then → IDLE.
    - start=1 with c1=1 in this cycle still commits the word, then goes directly to SHIFT.
- Commit rules (DONE cycle):
  - valid=0, or valid=1 with ack=1 in the same cycle: data_out ← assembled word, valid ← 1.
  - valid=1 with ack=0: word dropped, data_out unchanged, overrun ← 1.
- Handshake:
  - ack=1 while valid=1 clears valid on the next edge, unless a commit occurs in that same cycle (commit wins, valid stays 1).
  - ack while valid=0 has no effect.
  - overrun is cleared only by reset or by an ack accepted while overrun=1.
- Latency: valid rises one MCLK after the edge that takes the N-th sample.
- busy = (state==SHIFT), registered.
- Bit counter width: ceil(log2(DATA_WIDTH+2)). It never wraps within a frame.
- c1 held low during SHIFT freezes the frame indefinitely. No timeout.

Optional Feature:
- DBG_CAPTURE_PARITY_EN.
- Defined:
  - The frame carries one extra trailing bit: even parity over the data bits, sampled after the last data bit. It is not shifted into data_out.
  - At commit, parity_err ← (XOR of data bits) XOR parity bit.
  - A dropped (overrun) frame does not update parity_err.
- Undefined:
  - Frame is exactly DATA_WIDTH bits.
  - parity_err is tied to 0; no parity logic is present.

Test Plan:
- DATA_WIDTH=8, MSB_FIRST=0, c1 every 2nd MCLK: start, then sin bits 1,0,1,0,0,1,0,1 on successive c1 edges → data_out=0xA5, valid=1 one MCLK after the 8th sample, busy falls, overrun=0.
- MSB_FIRST=1, same bit sequence → data_out=0xA5. Then ack=1 → valid=0 next edge.
- Two back-to-back frames 0x3C then 0xFF with no ack → data_out stays 0x3C, overrun=1. Then ack → valid=0 and overrun=0.
- Start, 4 bits shifted, start again, then 8 bits of 0x81 → data_out=0x81; the aborted partial frame is never committed.
- reset pulled low after 5 bits of a frame → all outputs 0 immediately. A following full frame of 0x5A → data_out=0x5A.
- With DBG_CAPTURE_PARITY_EN: send 0x07 with parity bit 1 → parity_err=0. Send 0x07 with parity bit 0 → parity_err=1, data_out=0x07.
